ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline: consumes the decoded ALU operation and operands from the ID/EX register and produces the GPR write-back value for the EX/MEM register. Owns the HI/LO registers. Contains a 32-iteration sequential divider that stalls the upstream pipeline while busy.

---
 rtl/ex_pkg.sv | 50 +++++
 rtl/ex_div_unit.sv | 107 ++++++++++
 rtl/ex_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the MIPS execute stage.
// Holds the ALU class/subtype encodings produced by ID, the divider state
// encoding and the divider result record.
package ex_pkg;

  // Operation classes (alu_sel_i)
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_DIV   = 3'b101;

  // Operation subtypes (alu_op_i)
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h00;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;

  // Divider states
  typedef logic [1:0] div_state_t;
  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

  // Divider result: quotient goes to LO, remainder to HI
  typedef struct packed {
    logic [31:0] quo;
    logic [31:0] rem;
  } div_res_t;

  // Magnitude of a value, treating it as two's complement only when signed
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
    return (use_sign && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// div_unit: 32-iteration restoring divider for DIV/DIVU.
// Divides magnitudes, then sign-corrects in DONE. Divide by zero skips the
// iterations and reports quo=0xFFFFFFFF, rem=raw dividend.
module div_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_t  state_r;
  logic [4:0]  count_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [31:0] dividend_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div0_r;
  logic [32:0] trial_s;
  logic [32:0] sub_s;
  div_res_t    res_s;

  assign trial_s = {rem_r, quo_r[31]};
  assign sub_s   = trial_s - {1'b0, dvs_r};

  // Divider FSM, iteration counter and partial remainder/quotient
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DIV_IDLE;
      count_r    <= 5'd0;
      quo_r      <= 32'd0;
      rem_r      <= 32'd0;
      dvs_r      <= 32'd0;
      dividend_r <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div0_r     <= 1'b0;
    end else if (abort) begin
      state_r <= DIV_IDLE;
      count_r <= 5'd0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start) begin
            dividend_r <= dividend;
            count_r    <= 5'd0;
            if (divisor == 32'd0) begin
              div0_r  <= 1'b1;
              state_r <= DIV_DONE;
            end else begin
              div0_r  <= 1'b0;
              quo_r   <= abs32(dividend, sgn);
              rem_r   <= 32'd0;
              dvs_r   <= abs32(divisor, sgn);
              neg_q_r <= sgn & (dividend[31] ^ divisor[31]);
              neg_r_r <= sgn & dividend[31];
              state_r <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (trial_s >= {1'b0, dvs_r}) begin
            rem_r <= sub_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= trial_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= DIV_DONE;
          end else begin
            state_r <= DIV_BUSY;
          end
        end
        DIV_DONE: state_r <= DIV_IDLE;
        default:  state_r <= DIV_IDLE;
      endcase
    end
  end

  // Handshake outputs and sign-corrected result
  always_comb begin
    busy = ~abort & (((state_r == DIV_IDLE) & start) | (state_r == DIV_BUSY));
    done = ~abort & (state_r == DIV_DONE);
    if (div0_r) begin
      res_s.quo = 32'hFFFF_FFFF;
      res_s.rem = dividend_r;
    end else begin
      res_s.quo = neg_q_r ? (32'd0 - quo_r) : quo_r;
      res_s.rem = neg_r_r ? (32'd0 - rem_r) : rem_r;
    end
    quo = res_s.quo;
    rem = res_s.rem;
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Combinational ALU (logic/shift/move/arith), HI/LO registers, and an
// optional sequential divider enabled by defining EX_DIV_EN.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alu_op_i,
  input  logic [2:0]  alu_sel_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        wreg_en_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic        flush_i,
  output logic [31:0] wdata_o,
  output logic        wreg_en_o,
  output logic [4:0]  wreg_addr_o,
  output logic        stall_req_o
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] result_s;
  logic        gpr_s;
  logic        hi_we_s;
  logic        lo_we_s;
  logic [31:0] hi_nx_s;
  logic [31:0] lo_nx_s;
  logic        div_start_s;
  logic        div_signed_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [31:0] div_quo_s;
  logic [31:0] div_rem_s;

`ifdef EX_DIV_EN
  div_unit u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .sgn      (div_signed_s),
    .dividend (op1_i),
    .divisor  (op2_i),
    .abort    (flush_i),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quo      (div_quo_s),
    .rem      (div_rem_s)
  );
`else
  assign div_busy_s = 1'b0;
  assign div_done_s = 1'b0;
  assign div_quo_s  = 32'd0;
  assign div_rem_s  = 32'd0;
`endif

  // Decode the operation into a GPR result and HI/LO write requests
  always_comb begin
    result_s     = 32'd0;
    gpr_s        = 1'b0;
    hi_we_s      = 1'b0;
    lo_we_s      = 1'b0;
    hi_nx_s      = hi_r;
    lo_nx_s      = lo_r;
    div_start_s  = 1'b0;
    div_signed_s = 1'b0;
    case (alu_sel_i)
      SEL_NOP: gpr_s = 1'b1;
      SEL_LOGIC: begin
        gpr_s = 1'b1;
        case (alu_op_i)
          OP_OR:   result_s = op1_i | op2_i;
          OP_AND:  result_s = op1_i & op2_i;
          OP_XOR:  result_s = op1_i ^ op2_i;
          OP_NOR:  result_s = ~(op1_i | op2_i);
          default: gpr_s = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        gpr_s = 1'b1;
        case (alu_op_i)
          OP_SLL:  result_s = op2_i << op1_i[4:0];
          OP_SRL:  result_s = op2_i >> op1_i[4:0];
          OP_SRA:  result_s = $unsigned($signed(op2_i) >>> op1_i[4:0]);
          default: gpr_s = 1'b0;
        endcase
      end
      SEL_MOVE: begin
        case (alu_op_i)
          OP_MFHI: begin result_s = hi_r; gpr_s = 1'b1; end
          OP_MFLO: begin result_s = lo_r; gpr_s = 1'b1; end
          OP_MTHI: begin hi_we_s = 1'b1; hi_nx_s = op1_i; end
          OP_MTLO: begin lo_we_s = 1'b1; lo_nx_s = op1_i; end
          default: gpr_s = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        gpr_s = 1'b1;
        case (alu_op_i)
          OP_ADDU: result_s = op1_i + op2_i;
          OP_SUBU: result_s = op1_i - op2_i;
          OP_SLT:  result_s = {31'd0, $signed(op1_i) < $signed(op2_i)};
          OP_SLTU: result_s = {31'd0, op1_i < op2_i};
          default: gpr_s = 1'b0;
        endcase
      end
`ifdef EX_DIV_EN
      SEL_DIV: begin
        case (alu_op_i)
          OP_DIV:  begin div_start_s = 1'b1; div_signed_s = 1'b1; end
          OP_DIVU: begin div_start_s = 1'b1; div_signed_s = 1'b0; end
          default: div_start_s = 1'b0;
        endcase
      end
`endif
      default: gpr_s = 1'b0;
    endcase
    // Divider completion owns HI/LO for its DONE cycle
    if (div_done_s) begin
      hi_we_s = 1'b1;
      lo_we_s = 1'b1;
      hi_nx_s = div_rem_s;
      lo_nx_s = div_quo_s;
    end else begin
      div_signed_s = div_signed_s;
    end
  end

  // HI/LO registers; a flushed instruction never writes them
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      if (hi_we_s && !flush_i) hi_r <= hi_nx_s;
      if (lo_we_s && !flush_i) lo_r <= lo_nx_s;
    end
  end

  // Outputs to EX/MEM, held quiet while reset is asserted
  always_comb begin
    if (rst) begin
      wdata_o     = 32'd0;
      wreg_en_o   = 1'b0;
      wreg_addr_o = 5'd0;
      stall_req_o = 1'b0;
    end else begin
      wdata_o     = result_s;
      wreg_en_o   = wreg_en_i & gpr_s & ~flush_i;
      wreg_addr_o = wreg_addr_i;
      stall_req_o = div_busy_s;
    end
  end

endmodule
